store_buffer: RTL and testbench

Posted-write buffer between the pipeline MEM stage and the single-port word-addressed data memory. Stores from the pipeline are queued in a small FIFO and retired to memory in cycles when no load needs the memory port. Loads go to memory directly, or are served from the youngest matching buffered store. The MEM stage stalls only when the buffer is full or a load cannot be served.

---
 rtl/store_buffer_if.sv | 32 +++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: pipeline MEM-stage store/load handshakes plus the
// data-memory port. The buffer itself takes the slave view; the pipeline and
// memory environment together take the master view.
interface store_buffer_if #(
    parameter int AW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          empty;
    logic          mem_writeenable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_readdata,
        input  st_ready, ld_ready, ld_data, empty,
               mem_writeenable, mem_addr, mem_writedata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_readdata,
        output st_ready, ld_ready, ld_data, empty,
               mem_writeenable, mem_addr, mem_writedata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port word-addressed memory.
// Stores are queued and retired in program order whenever the memory port is
// not needed by a load; loads read memory directly.
// Build option STORE_BUF_FWD_EN: when defined, a load is served from the
// youngest buffered store to the same address. When undefined, such a load is
// held off (ld_ready=0) while the buffer drains until no matching entry is left,
// and then reads memory.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          is_empty;
    logic          match_any;
    logic [PW-1:0] idx;
    logic          blk;
    logic          drain;
    logic          st_ok;
    logic          enq;
`ifdef STORE_BUF_FWD_EN
    logic [31:0]   fwd_data;
`endif

    // Address match against valid entries; oldest to youngest so the youngest wins.
    always_comb begin
        match_any = 1'b0;
        idx       = '0;
`ifdef STORE_BUF_FWD_EN
        fwd_data  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == bus.ld_addr)) begin
                match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
                fwd_data  = data_q[idx];
`endif
            end
        end
    end

    // Drain / accept decision; reset blocks both so nothing leaks out mid-reset.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        is_empty = (count_q == '0);
`ifdef STORE_BUF_FWD_EN
        blk      = 1'b0;
`else
        blk      = match_any;
`endif
        drain    = !reset && !is_empty && (!bus.ld_valid || full || blk);
        st_ok    = !reset && !full;
        enq      = bus.st_valid && st_ok;
    end

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            addr_d[tail_q] = bus.st_addr;
            data_d[tail_q] = bus.st_data;
            tail_d         = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Memory port and pipeline-facing outputs.
    always_comb begin
        bus.st_ready        = st_ok;
        bus.empty           = is_empty;
        bus.mem_writeenable = drain;
        bus.mem_addr        = drain ? addr_q[head_q] : bus.ld_addr;
        bus.mem_writedata   = drain ? data_q[head_q] : 32'h0;
        bus.ld_ready        = bus.ld_valid && !drain;
`ifdef STORE_BUF_FWD_EN
        bus.ld_data         = match_any ? fwd_data : bus.mem_readdata;
`else
        bus.ld_data         = bus.mem_readdata;
`endif
    end

    // Pointer and occupancy registers; reset discards every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic reset;

    store_buffer_if #(.AW(AW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory as the DUT sees it (written from the DUT's write port) and the
    // model's idea of what memory should contain.
    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    assign bus.mem_readdata = tb_mem[bus.mem_addr[7:0]];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t sbq[$];

    typedef struct packed {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        e_st_ready;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic        e_ld_ready;
        logic [31:0] e_ld_data;
    } vec_t;
    vec_t tbl[12];

    int checks   = 0;
    int failures = 0;

    logic        obs_st_ready, obs_empty, obs_we, obs_ld_ready;
    logic [31:0] obs_maddr, obs_wdata, obs_ld_data;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, check against the model mid-cycle, then advance
    // both memories and the model at the edge.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic rs);
        logic        hit, e_full, e_blk, e_drain, e_st_ready, e_ld_ready;
        logic [31:0] e_ld_data, e_maddr, e_wdata;
`ifdef STORE_BUF_FWD_EN
        logic [31:0] fwd;
`endif
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        reset        = rs;
        @(negedge clk);

        e_full    = (sbq.size() == DEPTH);
        hit       = 1'b0;
        e_ld_data = ref_mem[la[7:0]];
`ifdef STORE_BUF_FWD_EN
        fwd = '0;
        foreach (sbq[i]) if (sbq[i].addr == la) begin hit = 1'b1; fwd = sbq[i].data; end
        e_blk = 1'b0;
        if (hit) e_ld_data = fwd;
`else
        foreach (sbq[i]) if (sbq[i].addr == la) hit = 1'b1;
        e_blk = hit;
`endif
        e_drain    = !rs && (sbq.size() > 0) && (!lv || e_full || e_blk);
        e_st_ready = !rs && !e_full;
        e_ld_ready = lv && !e_drain;
        e_maddr    = e_drain ? sbq[0].addr : la;
        e_wdata    = e_drain ? sbq[0].data : 32'h0;

        obs_st_ready = bus.st_ready;
        obs_empty    = bus.empty;
        obs_we       = bus.mem_writeenable;
        obs_maddr    = bus.mem_addr;
        obs_wdata    = bus.mem_writedata;
        obs_ld_ready = bus.ld_ready;
        obs_ld_data  = bus.ld_data;

        chk1("model_st_ready", obs_st_ready, e_st_ready);
        chk1("model_we", obs_we, e_drain);
        chk32("model_mem_addr", obs_maddr, e_maddr);
        chk32("model_wdata", obs_wdata, e_wdata);
        if (!rs) begin
            chk1("model_empty", obs_empty, sbq.size() == 0);
            chk1("model_ld_ready", obs_ld_ready, e_ld_ready);
            if (e_ld_ready) chk32("model_ld_data", obs_ld_data, e_ld_data);
        end

        @(posedge clk);
        if (obs_we) tb_mem[obs_maddr[7:0]] = obs_wdata;
        if (rs) begin
            sbq.delete();
        end else begin
            if (e_drain) begin
                ref_mem[sbq[0].addr[7:0]] = sbq[0].data;
                void'(sbq.pop_front());
            end
            if (sv && e_st_ready) sbq.push_back('{addr: sa, data: sd});
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'hD000_0000 | 32'(i);
            ref_mem[i] = 32'hD000_0000 | 32'(i);
        end
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0;
        reset = 1'b1;

        // Reset, then idle, then one store retiring the next cycle.
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk1("in_reset_st_ready", obs_st_ready, 1'b0);
        chk1("in_reset_we", obs_we, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle();
        chk1("rst_st_ready", obs_st_ready, 1'b1);
        chk1("rst_empty", obs_empty, 1'b1);
        chk1("rst_we", obs_we, 1'b0);
        cycle(1'b1, 32'd5, 32'hAAAA_0005, 1'b0, 32'h0, 1'b0);
        chk1("st5_accept_we", obs_we, 1'b0);
        idle();
        chk1("st5_retire_we", obs_we, 1'b1);
        chk32("st5_retire_addr", obs_maddr, 32'd5);
        chk32("st5_retire_data", obs_wdata, 32'hAAAA_0005);
        idle();
        chk1("st5_after_empty", obs_empty, 1'b1);
        chk32("st5_mem", tb_mem[5], 32'hAAAA_0005);

        // Continuous loads while the buffer fills; drains only when full or idle.
        tbl[0]  = '{1'b1, 32'd1, 32'h101, 1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[1]  = '{1'b1, 32'd2, 32'h102, 1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[2]  = '{1'b1, 32'd3, 32'h103, 1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[3]  = '{1'b1, 32'd4, 32'h104, 1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[4]  = '{1'b1, 32'd5, 32'h105, 1'b1, 32'd100, 1'b0, 1'b1, 32'd1,   32'h101, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'd5, 32'h105, 1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[6]  = '{1'b0, 32'd0, 32'h0,   1'b1, 32'd100, 1'b0, 1'b1, 32'd2,   32'h102, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'd0, 32'h0,   1'b1, 32'd100, 1'b1, 1'b0, 32'd100, 32'h0,   1'b1, 32'hD000_0064};
        tbl[8]  = '{1'b0, 32'd0, 32'h0,   1'b0, 32'd0,   1'b1, 1'b1, 32'd3,   32'h103, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'd0, 32'h0,   1'b0, 32'd0,   1'b1, 1'b1, 32'd4,   32'h104, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'd0, 32'h0,   1'b0, 32'd0,   1'b1, 1'b1, 32'd5,   32'h105, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'd0, 32'h0,   1'b0, 32'd0,   1'b1, 1'b0, 32'd0,   32'h0,   1'b0, 32'h0};
        for (int v = 0; v < 12; v++) begin
            cycle(tbl[v].sv, tbl[v].sa, tbl[v].sd, tbl[v].lv, tbl[v].la, 1'b0);
            chk1("tbl_st_ready", obs_st_ready, tbl[v].e_st_ready);
            chk1("tbl_we", obs_we, tbl[v].e_we);
            chk32("tbl_mem_addr", obs_maddr, tbl[v].e_maddr);
            chk32("tbl_wdata", obs_wdata, tbl[v].e_wdata);
            chk1("tbl_ld_ready", obs_ld_ready, tbl[v].e_ld_ready);
            if (tbl[v].e_ld_ready) chk32("tbl_ld_data", obs_ld_data, tbl[v].e_ld_data);
        end

        // Two stores to addr 7 held behind a load stream, then a load of addr 7.
        cycle(1'b1, 32'd7, 32'h11, 1'b1, 32'd50, 1'b0);
        cycle(1'b1, 32'd7, 32'h22, 1'b1, 32'd50, 1'b0);
`ifdef STORE_BUF_FWD_EN
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 32'd7, 1'b0);
        chk1("fwd7_ld_ready", obs_ld_ready, 1'b1);
        chk32("fwd7_ld_data", obs_ld_data, 32'h22);
        chk1("fwd7_we", obs_we, 1'b0);
        idle();
        chk32("fwd7_drain1", obs_wdata, 32'h11);
        idle();
        chk32("fwd7_drain2", obs_wdata, 32'h22);
`else
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 32'd7, 1'b0);
        chk1("blk7_stall1", obs_ld_ready, 1'b0);
        chk32("blk7_drain1", obs_wdata, 32'h11);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 32'd7, 1'b0);
        chk1("blk7_stall2", obs_ld_ready, 1'b0);
        chk32("blk7_drain2", obs_wdata, 32'h22);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 32'd7, 1'b0);
        chk1("blk7_ld_ready", obs_ld_ready, 1'b1);
        chk32("blk7_ld_data", obs_ld_data, 32'h22);
        chk1("blk7_we", obs_we, 1'b0);
`endif
        chk32("mem7", tb_mem[7], 32'h22);

        // Load to an address not in the buffer goes straight to memory.
        cycle(1'b1, 32'd3, 32'h33, 1'b1, 32'd50, 1'b0);
        cycle(1'b0, 32'd0, 32'h0, 1'b1, 32'd9, 1'b0);
        chk1("ld9_ready", obs_ld_ready, 1'b1);
        chk32("ld9_data", obs_ld_data, 32'hD000_0009);
        chk1("ld9_we", obs_we, 1'b0);
        idle();
        chk32("st3_retire_addr", obs_maddr, 32'd3);
        idle();

        // Reset with three stores pending discards them.
        cycle(1'b1, 32'd20, 32'hE20, 1'b1, 32'd50, 1'b0);
        cycle(1'b1, 32'd21, 32'hE21, 1'b1, 32'd50, 1'b0);
        cycle(1'b1, 32'd22, 32'hE22, 1'b1, 32'd50, 1'b0);
        cycle(1'b0, 32'd0, 32'h0, 1'b0, 32'd0, 1'b1);
        chk1("midrst_we", obs_we, 1'b0);
        chk1("midrst_st_ready", obs_st_ready, 1'b0);
        idle();
        chk1("postrst_empty", obs_empty, 1'b1);
        chk1("postrst_we", obs_we, 1'b0);
        idle();
        for (int a = 20; a <= 22; a++)
            chk32("postrst_mem", tb_mem[a], 32'hD000_0000 | 32'(a));
        cycle(1'b1, 32'd30, 32'hABC, 1'b0, 32'd0, 1'b0);
        idle();
        chk32("postrst_store_addr", obs_maddr, 32'd30);
        chk32("postrst_store_data", obs_wdata, 32'hABC);

        // Ten back-to-back stores, no loads: each retires the following cycle.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'(40 + k), 32'h4000 + 32'(k), 1'b0, 32'd0, 1'b0);
            chk1("wrap_st_ready", obs_st_ready, 1'b1);
            if (k > 0) begin
                chk1("wrap_we", obs_we, 1'b1);
                chk32("wrap_addr", obs_maddr, 32'(40 + k - 1));
            end
        end
        idle();
        chk32("wrap_last_addr", obs_maddr, 32'd49);
        idle();
        chk1("wrap_empty", obs_empty, 1'b1);

        // Random traffic against the model.
        for (int r = 0; r < 500; r++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                  1'($urandom_range(0, 63) == 0));
        end
        for (int r = 0; r < 8; r++) idle();
        for (int a = 0; a < 256; a++) begin
            if (tb_mem[a] !== ref_mem[a]) chk32("final_mem", tb_mem[a], ref_mem[a]);
        end
        chk1("final_empty", obs_empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
